// File: rtl/fp_rf_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : fp_rf_pkg                                              |
// | Description : Shared types and encodings for the FP register file,   |
// |               its busy-bit scoreboard and the fcsr state.            |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package fp_rf_pkg;

  // CSR selector for the fcsr sub-fields
  typedef enum logic [1:0] {
    CSR_FFLAGS = 2'd0,
    CSR_FRM    = 2'd1,
    CSR_FCSR   = 2'd2,
    CSR_RSVD   = 2'd3
  } csr_sel_e;

  // Accrued exception flags, {NV,DZ,OF,UF,NX}
  typedef logic [4:0] flags_t;

  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  // Rounding-mode encodings
  localparam logic [2:0] FRM_RNE = 3'd0;
  localparam logic [2:0] FRM_RTZ = 3'd1;
  localparam logic [2:0] FRM_RDN = 3'd2;
  localparam logic [2:0] FRM_RUP = 3'd3;
  localparam logic [2:0] FRM_RMM = 3'd4;
  localparam logic [2:0] FRM_DYN = 3'd7;

  // Encodings 5..7 are not valid as a stored rounding mode (DYN is only
  // meaningful in an instruction's rm field), so decode must trap on them.
  function automatic logic frm_is_illegal(input logic [2:0] mode);
    return (mode > FRM_RMM);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fp_scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : fp_scoreboard                                          |
// | Description : Busy-bit vector for in-flight FP destinations, with    |
// |               set-over-clear priority and the issue hazard check.    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module fp_scoreboard
  import fp_rf_pkg::*;
#(
  parameter int NREGS  = 32,
  parameter int NREAD  = 3,
  parameter int ADDR_W = 5
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic [NREAD*ADDR_W-1:0] rd_addr,
  input  logic                    issue_valid,
  input  logic [NREAD-1:0]        issue_use,
  input  logic [ADDR_W-1:0]       issue_rd,
  input  logic                    clr_valid,
  input  logic [ADDR_W-1:0]       clr_rd,
  output logic                    issue_ready
);

  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] clr_mask;
  logic [NREGS-1:0] set_mask;
  logic [NREGS-1:0] busy_eff;

  // A register being written back this cycle already counts as free
  always_comb begin
    clr_mask = '0;
    if (clr_valid) clr_mask[clr_rd] = 1'b1;
    busy_eff = busy & ~clr_mask;
  end

  // Hazard check on the destination and every used source operand
  always_comb begin
    issue_ready = !busy_eff[issue_rd];
    for (int i = 0; i < NREAD; i++) begin
      if (issue_use[i] && busy_eff[rd_addr[i*ADDR_W +: ADDR_W]]) issue_ready = 1'b0;
    end
  end

  // Accepted issue marks its destination busy
  always_comb begin
    set_mask = '0;
    if (issue_valid && issue_ready) set_mask[issue_rd] = 1'b1;
  end

  // Busy vector update; set is applied after clear so set wins
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) busy <= '0;
    else        busy <= busy_eff | set_mask;
  end

endmodule
`default_nettype wire

// File: rtl/fp_regfile_scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : fp_regfile_scoreboard                                  |
// | Description : Multi-port FP register file with write bypass, busy    |
// |               scoreboard, load-over-FPU writeback arbitration and    |
// |               the fcsr (frm + sticky fflags) state.                  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module fp_regfile_scoreboard
  import fp_rf_pkg::*;
#(
  parameter  int DATA_W = 32,
  parameter  int NREGS  = 32,
  parameter  int NREAD  = 3,
  localparam int ADDR_W = $clog2(NREGS)
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic [NREAD*ADDR_W-1:0] rd_addr,
  output logic [NREAD*DATA_W-1:0] rd_data,
  input  logic                    issue_valid,
  input  logic [NREAD-1:0]        issue_use,
  input  logic [ADDR_W-1:0]       issue_rd,
  output logic                    issue_ready,
  input  logic                    fpu_wb_valid,
  input  logic [ADDR_W-1:0]       fpu_wb_rd,
  input  logic [DATA_W-1:0]       fpu_wb_data,
  input  logic [4:0]              fpu_wb_flags,
  output logic                    fpu_wb_ready,
  input  logic                    ld_wb_valid,
  input  logic [ADDR_W-1:0]       ld_wb_rd,
  input  logic [DATA_W-1:0]       ld_wb_data,
  input  logic                    csr_we,
  input  logic [1:0]              csr_sel,
  input  logic [7:0]              csr_wdata,
  output logic [7:0]              csr_rdata,
  output logic [2:0]              frm,
  output logic                    frm_illegal,
  output logic [4:0]              fflags
);

  logic [DATA_W-1:0] regs [NREGS];
  logic              wb_valid;
  logic [ADDR_W-1:0] wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic              fpu_accept;
  flags_t            fflags_next;
  logic [2:0]        frm_next;
  csr_sel_e          sel;

  // Load path always wins; the FPU stalls while a load writes back
  always_comb begin
    fpu_wb_ready = !ld_wb_valid;
    fpu_accept   = fpu_wb_valid && !ld_wb_valid;
    wb_valid     = ld_wb_valid || fpu_wb_valid;
    wb_rd        = ld_wb_valid ? ld_wb_rd   : fpu_wb_rd;
    wb_data      = ld_wb_valid ? ld_wb_data : fpu_wb_data;
  end

  // Combinational read ports with bypass of the winning writeback
  for (genvar i = 0; i < NREAD; i++) begin : g_read
    logic [ADDR_W-1:0] addr;
    assign addr = rd_addr[i*ADDR_W +: ADDR_W];
    assign rd_data[i*DATA_W +: DATA_W] = (wb_valid && (wb_rd == addr)) ? wb_data : regs[addr];
  end

  // Register storage: at most one write per cycle
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int r = 0; r < NREGS; r++) regs[r] <= '0;
    end else if (wb_valid) begin
      regs[wb_rd] <= wb_data;
    end
  end

  fp_scoreboard #(
    .NREGS (NREGS),
    .NREAD (NREAD),
    .ADDR_W(ADDR_W)
  ) u_scoreboard (
    .clk        (clk),
    .n_rst      (n_rst),
    .rd_addr    (rd_addr),
    .issue_valid(issue_valid),
    .issue_use  (issue_use),
    .issue_rd   (issue_rd),
    .clr_valid  (wb_valid),
    .clr_rd     (wb_rd),
    .issue_ready(issue_ready)
  );

  assign sel = csr_sel_e'(csr_sel);

  // Next fcsr state: CSR write first, then accepted FPU flags OR'd on top
  // so a simultaneous fflags write never loses exception flags
  always_comb begin
    fflags_next = fflags;
    frm_next    = frm;
    if (csr_we) begin
      case (sel)
        CSR_FFLAGS: fflags_next = csr_wdata[4:0];
        CSR_FRM:    frm_next    = csr_wdata[2:0];
        CSR_FCSR: begin
          fflags_next = csr_wdata[4:0];
          frm_next    = csr_wdata[7:5];
        end
        default: ;
      endcase
    end
    if (fpu_accept) fflags_next = fflags_next | fpu_wb_flags;
  end

  // fcsr state registers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      fflags <= '0;
      frm    <= '0;
    end else begin
      fflags <= fflags_next;
      frm    <= frm_next;
    end
  end

  // CSR read returns the pre-write values
  always_comb begin
    csr_rdata = '0;
    case (sel)
      CSR_FFLAGS: csr_rdata = {3'b000, fflags};
      CSR_FRM:    csr_rdata = {5'b00000, frm};
      CSR_FCSR:   csr_rdata = {frm, fflags};
      default:    csr_rdata = '0;
    endcase
  end

  assign frm_illegal = frm_is_illegal(frm);

endmodule
`default_nettype wire
